// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter that shares one word-addressed system bus between
//   NumMasters requesters. One transaction may be outstanding at a time: the
//   selected master owns the bus from arbitration until its response (or a
//   timeout error) is routed back.
//
// Ports
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   m_req_i/m_we_i      per-master request / write enable
//   m_be_i              per-master byte enables, master k at [4k+3:4k]
//   m_addr_i            per-master word address, master k at [AW*k +: AW]
//   m_wdata_i           per-master write data, master k at [32k +: 32]
//   m_gnt_o             request accepted by the slave (one-hot or zero)
//   m_rvalid_o          response valid (one-hot or zero)
//   m_err_o             response is a timeout error (qualified by m_rvalid_o)
//   m_rdata_o           shared read data (qualified by m_rvalid_o)
//   s_*_o               slave-side request of the selected master
//   s_gnt_i, s_rvalid_i, s_rdata_i   slave-side handshake and response
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned NumMasters    = 2,
  parameter int unsigned AddrWidth     = 30,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMasters-1:0]           m_req_i,
  input  logic [NumMasters-1:0]           m_we_i,
  input  logic [4*NumMasters-1:0]         m_be_i,
  input  logic [AddrWidth*NumMasters-1:0] m_addr_i,
  input  logic [32*NumMasters-1:0]        m_wdata_i,
  output logic [NumMasters-1:0]           m_gnt_o,
  output logic [NumMasters-1:0]           m_rvalid_o,
  output logic [NumMasters-1:0]           m_err_o,
  output logic [31:0]                     m_rdata_o,
  output logic                            s_req_o,
  output logic                            s_we_o,
  output logic [3:0]                      s_be_o,
  output logic [AddrWidth-1:0]            s_addr_o,
  output logic [31:0]                     s_wdata_o,
  input  logic                            s_gnt_i,
  input  logic                            s_rvalid_i,
  input  logic [31:0]                     s_rdata_i
);

  localparam int unsigned SelW = $clog2(NumMasters);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  localparam logic [SelW:0]   NumM     = (SelW+1)'(NumMasters);
  localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Per-master request fields unpacked so the selected master can be muxed
  // by a plain array index.
  logic [3:0]           be_arr    [NumMasters];
  logic [AddrWidth-1:0] addr_arr  [NumMasters];
  logic [31:0]          wdata_arr [NumMasters];

  for (genvar k = 0; k < NumMasters; k++) begin : g_unpack
    assign be_arr[k]    = m_be_i[4*k +: 4];
    assign addr_arr[k]  = m_addr_i[AddrWidth*k +: AddrWidth];
    assign wdata_arr[k] = m_wdata_i[32*k +: 32];
  end

  // Round-robin search: start one past the last completed master and wrap.
  // idx is one bit wider than sel so last+i never overflows before the wrap.
  logic [SelW-1:0] winner;
  logic [SelW:0]   idx;
  logic            found;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= int'(NumMasters); i++) begin
      idx = {1'b0, last_q} + (SelW+1)'(i);
      if (idx >= NumM) idx = idx - NumM;
      if (!found && m_req_i[idx[SelW-1:0]]) begin
        winner = idx[SelW-1:0];
        found  = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_addr_o   = '0;
    s_wdata_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (|m_req_i) begin
          sel_d   = winner;
          state_d = StReq;
        end
      end

      StReq: begin
        s_req_o   = 1'b1;
        s_we_o    = m_we_i[sel_q];
        s_be_o    = be_arr[sel_q];
        s_addr_o  = addr_arr[sel_q];
        s_wdata_o = wdata_arr[sel_q];
        if (s_gnt_i) begin
          m_gnt_o[sel_q] = 1'b1;
          cnt_d          = '0;
          state_d        = StWait;
        end
      end

      StWait: begin
        // Saturating so a very long stall can never wrap back below the limit.
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        // A real response wins over a timeout landing in the same cycle.
        if (s_rvalid_i) begin
          m_rvalid_o[sel_q] = 1'b1;
          m_rdata_o         = s_rdata_i;
          last_d            = sel_q;
          state_d           = StIdle;
        end else if (cnt_q == CntLast) begin
          m_rvalid_o[sel_q] = 1'b1;
          m_err_o[sel_q]    = 1'b1;
          last_d            = sel_q;
          state_d           = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= SelW'(NumMasters - 1);  // master 0 gets first priority
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // The selected master must keep requesting until it is granted.
  a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StReq) |-> m_req_i[sel_q]);

endmodule
